// File: rtl/arb_pkg.sv
// Shared constants and helpers for the arbitrating multiplexer family.
package arb_pkg;

  // Arbitration modes selectable through the MODE parameter.
  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Width needed to hold a channel index; never narrower than one bit so a
  // single-channel instance still has a legal index port.
  function automatic int calc_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_pick.sv
// Combinational grant picker: finds the first requester at or after the
// round-robin pointer, wrapping around, by scanning a doubled request vector
// whose lower copy is masked below the pointer.
module rr_grant_pick
  import arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = calc_idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           mode,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any
);

  logic [IDW-1:0] w_base;
  logic [2*N-1:0] w_dbl;

  // Fixed priority always searches from channel 0.
  assign w_base = mode ? '0 : ptr;

  // Lower half keeps only requesters at or above the pointer; upper half is
  // the unmasked copy that supplies the wrapped-around candidates.
  always_comb begin
    w_dbl = '0;
    for (int i = 0; i < N; i++) begin
      w_dbl[i]     = req[i] && (i >= int'(w_base));
      w_dbl[N + i] = req[i];
    end
  end

  // Find-first over the doubled vector; the index folds back modulo N.
  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!any && w_dbl[j]) begin
        any       = 1'b1;
        grant_idx = IDW'((j >= N) ? (j - N) : j);
      end
    end
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrating multiplexer with valid/ready handshakes and a single
// registered output stage tagged with the winning channel index and grant.
module rr_arb_mux
  import arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = ARB_RR,
  parameter int IDW  = calc_idw(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [IDW-1:0] out_id,
  output logic [N-1:0]   out_grant,
  input  logic           out_ready
);

  logic           r_valid;
  logic [W-1:0]   r_data;
  logic [IDW-1:0] r_id;
  logic [N-1:0]   r_grant;
  logic [IDW-1:0] r_ptr;

  logic           w_load;
  logic [N-1:0]   w_grant;
  logic [IDW-1:0] w_idx;
  logic           w_any;
  logic [W-1:0]   w_data;

  // The output register may take new data when empty or being drained.
  assign w_load = !r_valid || out_ready;

  rr_grant_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req       (req_valid),
    .ptr       (r_ptr),
    .mode      (MODE == ARB_FIXED),
    .grant     (w_grant),
    .grant_idx (w_idx),
    .any       (w_any)
  );

  // Ready is withheld during reset so nothing is accepted into a register
  // that is being cleared.
  assign req_ready = (w_load && !rst) ? w_grant : '0;
  assign w_data    = req_data[w_idx * W +: W];

  // Output stage and round-robin pointer; a held output is never overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (w_any) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_id    <= w_idx;
        r_grant <= w_grant;
        if (MODE == ARB_RR)
          r_ptr <= (int'(w_idx) == N - 1) ? '0 : w_idx + IDW'(1);
      end else begin
        // Data and id keep their last value; only the valid/grant tags clear.
        r_valid <= 1'b0;
        r_grant <= '0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_id    = r_id;
  assign out_grant = r_grant;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: one round-robin instance and one
// fixed-priority instance sharing clock and reset.
module tb_rr_arb_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst;

  // Round-robin instance
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_id;
  logic [N-1:0]   out_grant;
  logic           out_ready;

  // Fixed-priority instance
  logic [N-1:0]   f_req_valid;
  logic [N*W-1:0] f_req_data;
  logic [N-1:0]   f_req_ready;
  logic           f_out_valid;
  logic [W-1:0]   f_out_data;
  logic [1:0]     f_out_id;
  logic [N-1:0]   f_out_grant;
  logic           f_out_ready;

  int n_cmp;
  int n_err;

  rr_arb_mux #(.N(N), .W(W), .MODE(0)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_grant (out_grant),
    .out_ready (out_ready)
  );

  rr_arb_mux #(.N(N), .W(W), .MODE(1)) u_fx (
    .clk       (clk),
    .rst       (rst),
    .req_valid (f_req_valid),
    .req_data  (f_req_data),
    .req_ready (f_req_ready),
    .out_valid (f_out_valid),
    .out_data  (f_out_data),
    .out_id    (f_out_id),
    .out_grant (f_out_grant),
    .out_ready (f_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rr_out(input string tag, input logic v, input logic [7:0] d,
                              input logic [1:0] id, input logic [3:0] g);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".id"},    32'(out_id),    32'(id));
    check({tag, ".grant"}, 32'(out_grant), 32'(g));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // ---------------- Reset with random inputs ----------------
    rst         = 1'b1;
    req_valid   = 4'($urandom);
    req_data    = 32'($urandom);
    out_ready   = 1'($urandom);
    f_req_valid = 4'hF;
    f_req_data  = 32'($urandom);
    f_out_ready = 1'b1;
    tick();
    tick();
    check_rr_out("rst", 1'b0, 8'h00, 2'd0, 4'b0000);
    check("rst.req_ready",   32'(req_ready),   32'h0);
    check("rst.f_req_ready", 32'(f_req_ready), 32'h0);
    check("rst.f_valid",     32'(f_out_valid), 32'h0);
    check("rst.f_grant",     32'(f_out_grant), 32'h0);

    req_valid   = '0;
    f_req_valid = '0;
    out_ready   = 1'b1;
    rst         = 1'b0;
    tick();
    tick();
    check("idle.valid", 32'(out_valid), 32'h0);
    check("idle.grant", 32'(out_grant), 32'h0);

    // ---------------- RR fairness, all valid ----------------
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'hA0 + 8'(i);
    req_valid = 4'hF;
    #1;
    check("rr.ready0", 32'(req_ready), 32'h1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_rr_out($sformatf("rr%0d", k), 1'b1, 8'hA0 + 8'(k % 4), 2'(k % 4),
                   4'(1 << (k % 4)));
      check($sformatf("rr%0d.ready", k), 32'(req_ready), 32'(1 << ((k + 1) % 4)));
    end

    // Drain with no requests: valid/grant clear, data/id hold.
    req_valid = '0;
    tick();
    check_rr_out("drain", 1'b0, 8'hA3, 2'd3, 4'b0000);

    // ---------------- Pointer wrap, sparse requests ----------------
    // Last grant was ch3, so the search restarts at ch0.
    req_valid = 4'b0101;
    tick();
    check_rr_out("sp0", 1'b1, 8'hA0, 2'd0, 4'b0001);
    tick();
    check_rr_out("sp1", 1'b1, 8'hA2, 2'd2, 4'b0100);
    tick();
    check_rr_out("sp2", 1'b1, 8'hA0, 2'd0, 4'b0001);
    // Grant ch1 so the pointer lands on ch2.
    req_valid = 4'b0010;
    tick();
    check_rr_out("sp3", 1'b1, 8'hA1, 2'd1, 4'b0010);
    req_valid = 4'b0101;
    tick();
    check_rr_out("sp4", 1'b1, 8'hA2, 2'd2, 4'b0100);

    // ---------------- Backpressure ----------------
    // Pointer is at ch3; only ch2 requests, so ch2 wins again.
    req_data[2*W +: W] = 8'h5C;
    req_valid = 4'b0100;
    tick();
    check_rr_out("bp.load", 1'b1, 8'h5C, 2'd2, 4'b0100);
    req_data[2*W +: W] = 8'h5D;
    out_ready = 1'b0;
    #1;
    check("bp.ready_pre", 32'(req_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_rr_out($sformatf("bp.hold%0d", k), 1'b1, 8'h5C, 2'd2, 4'b0100);
      check($sformatf("bp.hold%0d.ready", k), 32'(req_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp.ready_rel", 32'(req_ready), 32'b0100);
    tick();
    check_rr_out("bp.next", 1'b1, 8'h5D, 2'd2, 4'b0100);

    // ---------------- Reset mid-transfer ----------------
    req_data[1*W +: W] = 8'h77;
    req_valid = 4'b0010;
    tick();
    check_rr_out("mr.load", 1'b1, 8'h77, 2'd1, 4'b0010);
    req_valid = '0;
    out_ready = 1'b0;
    tick();
    check("mr.hold", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_rr_out("mr.async", 1'b0, 8'h00, 2'd0, 4'b0000);
    #1;
    rst = 1'b0;
    req_valid = 4'hF;
    out_ready = 1'b1;
    #1;
    check("mr.ready", 32'(req_ready), 32'h1);
    tick();
    check_rr_out("mr.first", 1'b1, 8'hA0, 2'd0, 4'b0001);
    tick();
    check_rr_out("mr.second", 1'b1, 8'h77, 2'd1, 4'b0010);
    req_valid = '0;

    // ---------------- Fixed priority ----------------
    f_req_data = 32'h33_00_11_00;
    f_req_valid = 4'b1010;
    f_out_ready = 1'b1;
    #1;
    check("fx.ready0", 32'(f_req_ready), 32'b0010);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("fx%0d.id", k),    32'(f_out_id),    32'd1);
      check($sformatf("fx%0d.data", k),  32'(f_out_data),  32'h11);
      check($sformatf("fx%0d.grant", k), 32'(f_out_grant), 32'b0010);
    end
    f_req_valid = 4'b1000;
    #1;
    check("fx.ready3", 32'(f_req_ready), 32'b1000);
    tick();
    check("fx.last.valid", 32'(f_out_valid), 32'h1);
    check("fx.last.id",    32'(f_out_id),    32'd3);
    check("fx.last.data",  32'(f_out_data),  32'h33);
    check("fx.last.grant", 32'(f_out_grant), 32'b1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel, W-bit arbitrating multiplexer with valid/ready handshakes on every input and on the output.
- Each cycle it picks at most one valid requester, using round-robin or fixed priority. The winner's data moves into a single registered output stage, tagged with its channel index and a one-hot grant.
- This is the next generation of the team's 2:1 mux and 4-output decoder. It sits between multiple producers and one shared consumer.

Parameters:
- N, 4, number of input channels (>=1).
- W, 8, data width per channel (>=1).
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- IDW, (N>1 ? $clog2(N) : 1), derived index width; not overridden by users.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  N  per-channel request valid.
- req_data  input  N*W  channel i data at [i*W +: W].
- req_ready  output  N  per-channel accept; combinational.
- out_valid  output  1  output register holds a transfer.
- out_data  output  W  registered data of the granted channel.
- out_id  output  IDW  registered index of the granted channel.
- out_grant  output  N  registered one-hot of out_id; all zero when out_valid=0.
- out_ready  input  1  consumer accept.

Behaviour:
- Interface: clock `clk`, reset `rst`. A single clock domain; `rst` is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_id=0, out_grant=0, RR pointer ptr=0.
- While rst=1, req_ready=0 (gated combinationally).
- load = !out_valid || out_ready.
  - A held output is never overwritten.
  - out_ready while out_valid=0 is ignored.
- Grant selection is combinational:
  - RR mode: first i with req_valid[i]=1, searching ptr, ptr+1, … wrapping N-1 to 0.
  - Fixed mode: lowest i with req_valid[i]=1; ptr unused and held at 0.
- req_ready[i] = load && grant[i] && !rst. At most one bit is set.
- A transfer on channel i occurs when req_valid[i] && req_ready[i].
- Clock edge with a transfer on channel g:
  - out_data <= data[g], out_id <= g, out_grant <= 1<<g, out_valid <= 1.
  - RR mode: ptr <= (g==N-1) ? 0 : g+1.
- Clock edge with load=1 and no valid request: out_valid <= 0 and out_grant <= 0. out_data and out_id hold their last value.
- Clock edge with load=0: all output registers and ptr hold.
- Latency and throughput:
  - One cycle from an input transfer to out_valid.
  - Throughput is one transfer per cycle when out_ready=1 continuously.
- Simultaneous events: the output is consumed and a new grant is loaded on the same edge, with no bubble.
- Fairness (RR): with all N channels continuously valid, each channel receives exactly one grant in every N consecutive transfers. A newly valid channel waits at most N-1 transfers.
- Requester rules:
  - Must hold req_valid and req_data stable until accepted.
  - Must not make req_valid depend on req_ready.
  - A channel dropping valid before acceptance is legal; it is simply not granted.
- Reset mid-operation: the output register contents are discarded immediately and asynchronously. Nothing in flight is retained. Arbitration resumes from ptr=0 after deassertion.
- N=1: degenerates to a registered valid/ready pipeline stage; out_id=0 and out_grant=out_valid.

Decomposition:
- Package arb_pkg holds:
  - Mode constants ARB_RR=0 and ARB_FIXED=1.
  - A function computing the index width (clog2 with a minimum of 1).
- Sub-module rr_grant_pick (combinational):
  - Inputs: req[N], ptr[IDW], mode.
  - Outputs: grant one-hot [N], grant_idx [IDW], any.
  - Implemented as a double-width masked find-first.
- The top level holds the output register, the pointer and the ready gating.

Test Plan:
- Reset/idle: assert rst with random inputs -> all outputs 0 and req_ready=0 during reset. After release with no valid inputs, out_valid stays 0.
- RR fairness: N=4, MODE=0, all valid, req_data[i]=8'hA0+i, out_ready=1 -> out_id sequence 0,1,2,3,0,1…, out_data A0,A1,A2,A3…, one transfer per cycle.
- Backpressure: single request on ch2 with data 8'h5C, out_ready=0 for 3 cycles:
  - Required: out_valid=1, out_data=5C, out_grant=4'b0100 held steady.
  - Required: req_ready=0 on all channels for those 3 cycles.
  - Then out_ready=1 -> the next pending request loads on the same edge.
- Fixed priority: MODE=1, channels 1 and 3 valid continuously -> ch1 is granted every cycle and ch3 never, until ch1 deasserts; then ch3 is granted.
- Pointer wrap and sparse requests: RR, after a grant to ch3 (ptr=0), only ch0 and ch2 valid -> grant ch0 then ch2. After a grant to ch1 (ptr=2), ch0 and ch2 valid -> grant ch2 first.
- Reset mid-transfer: out_valid=1 holding ch1 data, pulse rst between clock edges -> out_valid drops without waiting for an edge. After release, the first grant searches from ch0.
